// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction memory and its program loader.
// Provides the default memory depth, the matching address width, the header
// count width, the loader state encoding and a header range check.
package instr_mem_pkg;

    localparam int unsigned IMEM_DEPTH  = 64;
    localparam int unsigned IMEM_ADDR_W = $clog2(IMEM_DEPTH);
    localparam int unsigned HDR_W       = 16;

    typedef enum logic [2:0] {
        IDLE,
        HDR_LO,
        HDR_HI,
        COLLECT,
        WRITE,
        DONE
    } loader_state_t;

    // A header is usable when it asks for at least one word and no more than fit.
    function automatic logic count_ok(input logic [HDR_W-1:0] count, input int unsigned depth);
        return (count != '0) && (32'(count) <= depth);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles 32-bit little-endian words from a stream of accepted bytes.
// Ports:
//   clk, reset  - clock and asynchronous active-high reset
//   clear       - drop any partially assembled word
//   accept      - byte_data is consumed this cycle
//   byte_data   - incoming byte
//   word_c      - word formed by the current byte and the three held bytes
//   last_c      - this accepted byte completes a word (word_c is valid)
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_data,
    output logic [31:0] word_c,
    output logic        last_c
);

    logic [1:0]  byte_cnt;
    logic [23:0] shreg;

    // Older bytes shift toward bit 0, so the first byte ends up in [7:0].
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt <= '0;
            shreg    <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
            shreg    <= '0;
        end else if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= {byte_data, shreg[23:8]};
        end
    end

    assign word_c = {byte_data, shreg};
    assign last_c = accept && (byte_cnt == 2'd3);

endmodule

// File: rtl/instr_loader.sv
// Loads a program from a byte stream into instruction memory.
// Stream format: 16-bit little-endian word count, then count words of four
// little-endian bytes each. Words are written to consecutive addresses from 0.
// Ports:
//   clk, reset              - clock and asynchronous active-high reset
//   load_start              - begin a load (honoured only when idle)
//   abort                   - cancel the load in progress
//   byte_data/valid/ready   - byte stream handshake
//   store_address/data/en   - memory write port
//   busy                    - load in progress, also used to hold the core
//   load_done / load_err    - completion / rejected-header pulses
//   words_loaded            - words written by the current or last load
module instr_loader
    import instr_mem_pkg::*;
#(
    parameter int unsigned DEPTH = IMEM_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_start,
    input  logic                     abort,
    input  logic [7:0]               byte_data,
    input  logic                     byte_valid,
    output logic                     byte_ready,
    output logic [$clog2(DEPTH)-1:0] store_address,
    output logic [31:0]              store_data,
    output logic                     store_en,
    output logic                     busy,
    output logic                     load_done,
    output logic                     load_err,
    output logic [$clog2(DEPTH):0]   words_loaded
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned WL_W = AW + 1;

    loader_state_t    state;
    loader_state_t    next_state;
    logic [HDR_W-1:0] count;
    logic [HDR_W-1:0] hdr_count;
    logic [AW-1:0]    index;
    logic             xfer;
    logic             hdr_ok;
    logic             last_word;
    logic             pack_accept;
    logic             pack_clear;
    logic             pack_last;
    logic [31:0]      pack_word;

    assign xfer      = byte_valid && byte_ready;
    assign hdr_count = {byte_data, count[7:0]};
    assign hdr_ok    = count_ok(hdr_count, DEPTH);
    assign last_word = (HDR_W'(index) == (count - HDR_W'(1)));

    // Partial words only survive while collecting; any exit discards them.
    assign pack_accept = xfer && (state == COLLECT);
    assign pack_clear  = (state != COLLECT);

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (pack_clear),
        .accept    (pack_accept),
        .byte_data (byte_data),
        .word_c    (pack_word),
        .last_c    (pack_last)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort overrides everything outside IDLE.
    always_comb begin
        next_state = state;
        if ((state != IDLE) && abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (load_start) next_state = HDR_LO;
                HDR_LO:  if (xfer)       next_state = HDR_HI;
                HDR_HI:  if (xfer)       next_state = hdr_ok ? COLLECT : IDLE;
                COLLECT: if (pack_last)  next_state = WRITE;
                WRITE:   next_state = last_word ? DONE : COLLECT;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // State-decoded outputs; abort masks the write and done strobes in the
    // same cycle so a cancelled load never touches memory again.
    always_comb begin
        byte_ready = 1'b0;
        store_en   = 1'b0;
        load_done  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            HDR_LO, HDR_HI, COLLECT: byte_ready = !abort;
            WRITE:                   store_en   = !abort;
            DONE:                    load_done  = !abort;
            default: begin
            end
        endcase
    end

    // Header capture, write port registers, word index and progress count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count         <= '0;
            index         <= '0;
            words_loaded  <= '0;
            store_address <= '0;
            store_data    <= '0;
            load_err      <= 1'b0;
        end else begin
            load_err <= 1'b0;
            if ((state == HDR_LO) && xfer) begin
                count[7:0] <= byte_data;
            end
            if ((state == HDR_HI) && xfer) begin
                count[15:8] <= byte_data;
                if (hdr_ok) begin
                    index        <= '0;
                    words_loaded <= '0;
                end else begin
                    load_err <= 1'b1;
                end
            end
            // Write port only moves when a word completes, so it is stable otherwise.
            if (pack_last) begin
                store_address <= index;
                store_data    <= pack_word;
            end
            if (store_en) begin
                index        <= index + AW'(1);
                words_loaded <= words_loaded + WL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed scenarios plus random loads,
// compared against a byte-stream model of the expected memory writes.
module tb_instr_loader;
    import instr_mem_pkg::*;

    localparam int unsigned AW = IMEM_ADDR_W;
    localparam int          DEP = int'(IMEM_DEPTH);

    logic          clk;
    logic          reset;
    logic          load_start;
    logic          abort;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          byte_ready;
    logic [AW-1:0] store_address;
    logic [31:0]   store_data;
    logic          store_en;
    logic          busy;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   words_loaded;

    instr_loader #(.DEPTH(IMEM_DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .load_start    (load_start),
        .abort         (abort),
        .byte_data     (byte_data),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .store_address (store_address),
        .store_data    (store_data),
        .store_en      (store_en),
        .busy          (busy),
        .load_done     (load_done),
        .load_err      (load_err),
        .words_loaded  (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Observations gathered on every falling edge.
    int          obs_addr[$];
    logic [31:0] obs_data[$];
    int          n_done = 0;
    int          n_err = 0;
    int          negs = 0;
    int          last_xfer_neg = 0;
    int          last_we_neg = 0;
    int          last_done_neg = 0;
    int          ready_in_write = 0;
    int          n_unstable = 0;
    logic [AW-1:0] prev_a = '0;
    logic [31:0]   prev_d = '0;

    always @(negedge clk) begin
        negs++;
        if (byte_valid && byte_ready) last_xfer_neg = negs;
        if (store_en) begin
            obs_addr.push_back(int'(store_address));
            obs_data.push_back(store_data);
            last_we_neg = negs;
            if (byte_ready) ready_in_write++;
        end
        if (load_done) begin
            n_done++;
            last_done_neg = negs;
        end
        if (load_err) n_err++;
        if (!reset && !store_en && !abort &&
            ((store_address !== prev_a) || (store_data !== prev_d))) n_unstable++;
        prev_a = store_address;
        prev_d = store_data;
    end

    // Reference model state.
    logic [7:0]  tx[$];
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_err;
    int          exp_done;
    int          exp_wl;
    int          last_wl = 0;
    int          wb, db, eb;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        wb = obs_addr.size();
        db = n_done;
        eb = n_err;
    endtask

    // Program = count header followed by 4*count random bytes when the count is legal.
    task automatic make_prog(input int cnt);
        tx.delete();
        tx.push_back(8'(cnt & 255));
        tx.push_back(8'((cnt >> 8) & 255));
        if (cnt >= 1 && cnt <= DEP)
            for (int i = 0; i < 4 * cnt; i++) tx.push_back(8'($urandom));
    endtask

    // Expected writes derived straight from the byte stream.
    task automatic build_expect(input int wl_prev);
        int cnt;
        cnt = int'(tx[0]) + 256 * int'(tx[1]);
        exp_addr.delete();
        exp_data.delete();
        exp_err  = (cnt == 0 || cnt > DEP) ? 1 : 0;
        exp_done = 1 - exp_err;
        exp_wl   = (exp_err != 0) ? wl_prev : cnt;
        if (exp_err == 0) begin
            for (int i = 0; i < cnt; i++) begin
                exp_addr.push_back(i);
                exp_data.push_back(32'(tx[2 + 4*i])
                                 + (32'(tx[3 + 4*i]) << 8)
                                 + (32'(tx[4 + 4*i]) << 16)
                                 + (32'(tx[5 + 4*i]) << 24));
            end
        end
    endtask

    task automatic start_load();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        forever begin
            @(negedge clk);
            if (byte_ready) break;
            t++;
            if (t > 64) begin
                check("ready_timeout", 64'(byte_ready), 64'(1));
                break;
            end
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    task automatic send_range(input int lo, input int hi, input int maxgap);
        for (int i = lo; i < hi; i++) send_byte(tx[i], int'($urandom_range(0, maxgap)));
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag);
        int n;
        n = obs_addr.size() - wb;
        check({tag, "_nwrites"}, 64'(n), 64'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 64'(obs_addr[wb + i]), 64'(exp_addr[i]));
            check($sformatf("%s_data%0d", tag, i), 64'(obs_data[wb + i]), 64'(exp_data[i]));
        end
        check({tag, "_done"}, 64'(n_done - db), 64'(exp_done));
        check({tag, "_err"}, 64'(n_err - eb), 64'(exp_err));
        check({tag, "_words_loaded"}, 64'(words_loaded), 64'(exp_wl));
        check({tag, "_busy_after"}, 64'(busy), 64'(0));
        if (exp_done != 0) begin
            check({tag, "_we_latency"}, 64'(last_we_neg - last_xfer_neg), 64'(1));
            check({tag, "_done_latency"}, 64'(last_done_neg - last_xfer_neg), 64'(2));
        end
        last_wl = exp_wl;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_byte_ready"}, 64'(byte_ready), 64'(0));
        check({tag, "_store_en"}, 64'(store_en), 64'(0));
        check({tag, "_store_address"}, 64'(store_address), 64'(0));
        check({tag, "_store_data"}, 64'(store_data), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_load_done"}, 64'(load_done), 64'(0));
        check({tag, "_load_err"}, 64'(load_err), 64'(0));
        check({tag, "_words_loaded"}, 64'(words_loaded), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        reset      = 1'b1;
        load_start = 1'b0;
        abort      = 1'b0;
        byte_data  = 8'h00;
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Two-word program with known encodings.
        tx = {8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        snap();
        build_expect(last_wl);
        start_load();
        check("hdr_busy", 64'(busy), 64'(1));
        send_range(0, tx.size(), 0);
        settle();
        check_result("prog2");
        check("prog2_word0", 64'(obs_data[wb]), 64'(32'h0000_0513));
        check("prog2_word1", 64'(obs_data[wb + 1]), 64'(32'h0010_0593));

        // Rejected headers: zero and one past the depth.
        tx = {8'h00, 8'h00};
        snap();
        build_expect(last_wl);
        start_load();
        send_range(0, tx.size(), 1);
        settle();
        check_result("hdr_zero");
        tx = {8'h41, 8'h00};
        snap();
        build_expect(last_wl);
        start_load();
        send_range(0, tx.size(), 1);
        settle();
        check_result("hdr_65");

        // Full-depth load with random gaps in byte_valid.
        make_prog(DEP);
        snap();
        build_expect(last_wl);
        start_load();
        send_range(0, tx.size(), 3);
        settle();
        check_result("full");
        check("full_done_after_last_write", 64'(last_done_neg - last_we_neg), 64'(1));

        // Abort in the WRITE cycle of word 1 of 3.
        make_prog(3);
        snap();
        build_expect(last_wl);
        while (exp_addr.size() > 1) begin
            void'(exp_addr.pop_back());
            void'(exp_data.pop_back());
        end
        exp_done = 0;
        exp_wl   = 1;
        start_load();
        send_range(0, 10, 1);
        abort = 1'b1;
        @(negedge clk);
        check("abort_store_en", 64'(store_en), 64'(0));
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy_next", 64'(busy), 64'(0));
        @(posedge clk); #1;
        settle();
        check_result("abort");

        // Reset after two bytes of word 0, then a fresh load.
        make_prog(2);
        snap();
        start_load();
        send_range(0, 4, 0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        @(posedge clk); #1;
        reset = 1'b0;
        settle();
        check("midrst_no_write", 64'(obs_addr.size() - wb), 64'(0));
        last_wl = 0;
        make_prog(2);
        snap();
        build_expect(last_wl);
        start_load();
        send_range(0, tx.size(), 1);
        settle();
        check_result("after_rst");

        // load_start during COLLECT must be ignored.
        make_prog(3);
        snap();
        build_expect(last_wl);
        start_load();
        send_range(0, 7, 1);
        start_load();
        send_range(7, tx.size(), 1);
        settle();
        check_result("restart_ignored");

        // Random loads, legal and illegal counts.
        for (int k = 0; k < 6; k++) begin
            cnt = (k == 0) ? int'($urandom_range(65, 300)) : int'($urandom_range(0, 70));
            make_prog(cnt);
            snap();
            build_expect(last_wl);
            start_load();
            send_range(0, tx.size(), 2);
            settle();
            check_result($sformatf("rand%0d", k));
        end

        check("ready_during_write", 64'(ready_in_write), 64'(0));
        check("addr_data_stable", 64'(n_unstable), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of 32-bit words in the target instruction memory.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port load_start  input  1  one-cycle request to begin a program load.
REQ-005 SHALL have port abort  input  1  synchronous cancel of a load in progress.
REQ-006 SHALL have port byte_data  input  8  incoming program byte.
REQ-007 SHALL have port byte_valid  input  1  byte_data valid this cycle.
REQ-008 SHALL have port byte_ready  output  1  loader accepts byte this cycle; a transfer occurs when byte_valid and byte_ready are both high.
REQ-009 SHALL have port store_address  output  $clog2(DEPTH)  memory write address.
REQ-010 SHALL have port store_data  output  32  memory write data.
REQ-011 SHALL have port store_en  output  1  memory write strobe, one cycle per word.
REQ-012 SHALL have port busy  output  1  high while a load is in progress; doubles as core hold.
REQ-013 SHALL have port load_done  output  1  one-cycle pulse on successful completion.
REQ-014 SHALL have port load_err  output  1  one-cycle pulse on rejected header.
REQ-015 SHALL have port words_loaded  output  $clog2(DEPTH)+1  words written in the current/last load.

Function
REQ-016 SHALL implement states IDLE, HDR_LO, HDR_HI, COLLECT, WRITE, DONE.
REQ-017 SHALL go IDLE->HDR_LO on load_start; load_start in any other state is ignored.
REQ-018 SHALL take a 16-bit word count, low byte in HDR_LO then high byte in HDR_HI.
REQ-019 SHALL, if the count is 0 or greater than DEPTH, pulse load_err the cycle after the HDR_HI byte is accepted and return to IDLE with no write.
REQ-020 SHALL otherwise enter COLLECT, clear words_loaded, and set the word index to 0.
REQ-021 SHALL assemble each word from 4 bytes, little-endian: first byte is bits [7:0], fourth byte is bits [31:24].
REQ-022 SHALL assert byte_ready only in HDR_LO, HDR_HI and COLLECT; it SHALL be low in IDLE, WRITE and DONE.
REQ-023 SHALL hold partial assembly state indefinitely while byte_valid is low; there is no timeout.
REQ-024 SHALL enter WRITE the cycle after the fourth byte is accepted, driving store_en=1, store_address=index and store_data=the assembled word for exactly one cycle.
REQ-025 SHALL, on leaving WRITE, increment the index and words_loaded, then go to DONE if index equals count-1, else to COLLECT.
REQ-026 SHALL pulse load_done for one cycle in DONE, then return to IDLE; the last byte is accepted at cycle N, store_en is high at N+1, and load_done is high at N+2.
REQ-027 SHALL keep busy high in every state except IDLE.
REQ-028 SHALL, on abort in any non-IDLE state, go to IDLE next cycle with no store_en, no load_done and no load_err; abort in WRITE suppresses that write; abort takes priority over a byte transfer.
REQ-029 SHALL hold store_address and store_data stable when store_en is low, and SHALL never write an address >= DEPTH.
REQ-030 SHALL keep words_loaded after completion or abort until the next accepted header.

Reset
REQ-031 SHALL, while reset is high, put the state in IDLE and drive byte_ready=0, store_en=0, store_address=0, store_data=0, busy=0, load_done=0, load_err=0, words_loaded=0, and clear the index, count and partial word.
REQ-032 SHALL abandon a load on reset mid-operation, with no further store_en after reset deasserts.

Structure
REQ-033 SHALL take DEPTH, the address width and the loader state enum from the shared package instr_mem_pkg, which instr_mem_v2 also uses.
REQ-034 SHALL place byte-to-word assembly (byte counter plus shift register) in the sub-module byte_packer; the FSM, index and header logic stay in instr_loader.

Verification
REQ-035 SHALL cover: header 0x02,0x00, then bytes 13 05 00 00 93 05 10 00 -> store_en at addr 0 with 0x00000513, then at addr 1 with 0x00100593, then load_done, words_loaded=2.
REQ-036 SHALL cover: header 0x00,0x00 -> load_err pulse, no store_en; header 0x41,0x00 with DEPTH=64 -> load_err.
REQ-037 SHALL cover: count 64 with random gaps in byte_valid -> 64 writes at addresses 0..63, byte_ready low on each WRITE cycle, load_done after the write to addr 63.
REQ-038 SHALL cover: abort asserted in the same cycle as WRITE for word 1 of 3 -> no write to addr 1, busy low next cycle, no load_done.
REQ-039 SHALL cover: reset pulsed after 2 of 4 bytes of word 0 -> all outputs at reset values; a fresh load afterwards writes correct words starting at addr 0.
REQ-040 SHALL cover: load_start pulsed during COLLECT -> ignored, and the load completes normally.
